// File: rtl/divider_sequencer.sv
// Sequencer that drives one iterative divider for a single requester: accepts an
// N/D pair, runs the divider, traps divide-by-zero and guards the run with a watchdog.
module divider_sequencer #(
    parameter int INPUT_SIZE = 10,
    parameter int ITERATIONS = INPUT_SIZE,
    parameter int TIMEOUT    = ITERATIONS + 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [INPUT_SIZE-1:0] in_n,
    input  logic [INPUT_SIZE-1:0] in_d,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [INPUT_SIZE-1:0] out_q,
    output logic [INPUT_SIZE-1:0] out_r,
    output logic                  out_dz,
    output logic                  out_to,
    output logic                  busy,
    output logic                  div_load,
    output logic                  div_enable,
    output logic [INPUT_SIZE-1:0] div_init_counter,
    output logic [INPUT_SIZE-1:0] div_n,
    output logic [INPUT_SIZE-1:0] div_d,
    input  logic [INPUT_SIZE-1:0] div_q,
    input  logic [INPUT_SIZE-1:0] div_r,
    input  logic                  div_ready
);

    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT);
    localparam logic [WD_W-1:0] WD_ONE   = {{(WD_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } stateT;

    stateT           state;
    stateT           nextState;
    logic [WD_W-1:0] watchdog;
    logic            enableReg;
    logic            runArmed;
    logic            acceptReq;
    logic            readySeen;
    logic            wdExpired;

    // runArmed is only set after a full RUN cycle, masking a stale ready from the previous op
    assign acceptReq  = (state == IDLE) && in_valid;
    assign readySeen  = (state == RUN) && runArmed && div_ready;
    assign wdExpired  = (state == RUN) && (watchdog >= WD_LIMIT);
    assign div_enable = enableReg && !readySeen && !wdExpired;
    assign div_init_counter = INPUT_SIZE'(ITERATIONS);

    // Next-state decode
    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    nextState = (in_d == {INPUT_SIZE{1'b0}}) ? DONE : LOAD;
                end else begin
                    nextState = IDLE;
                end
            end
            LOAD: nextState = RUN;
            RUN: begin
                if (readySeen || wdExpired) begin
                    nextState = DONE;
                end else begin
                    nextState = RUN;
                end
            end
            DONE: begin
                if (out_ready) begin
                    nextState = IDLE;
                end else begin
                    nextState = DONE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    // State, registered handshake/control outputs, operand latch, watchdog and result capture
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            div_load  <= 1'b0;
            enableReg <= 1'b0;
            runArmed  <= 1'b0;
            watchdog  <= {WD_W{1'b0}};
            div_n     <= {INPUT_SIZE{1'b0}};
            div_d     <= {INPUT_SIZE{1'b0}};
            out_q     <= {INPUT_SIZE{1'b0}};
            out_r     <= {INPUT_SIZE{1'b0}};
            out_dz    <= 1'b0;
            out_to    <= 1'b0;
        end else begin
            state     <= nextState;
            in_ready  <= (nextState == IDLE);
            busy      <= (nextState != IDLE);
            out_valid <= (nextState == DONE);
            div_load  <= (nextState == LOAD);
            enableReg <= (nextState == LOAD) || (nextState == RUN);
            runArmed  <= (state == RUN);

            if (state == LOAD) begin
                watchdog <= {WD_W{1'b0}};
            end else if ((state == RUN) && !readySeen && (watchdog < WD_LIMIT)) begin
                watchdog <= watchdog + WD_ONE;
            end else begin
                watchdog <= watchdog;
            end

            if (acceptReq) begin
                div_n <= in_n;
                div_d <= in_d;
                if (in_d == {INPUT_SIZE{1'b0}}) begin
                    out_q  <= {INPUT_SIZE{1'b1}};
                    out_r  <= in_n;
                    out_dz <= 1'b1;
                    out_to <= 1'b0;
                end
            end else if (readySeen) begin
                out_q  <= div_q;
                out_r  <= div_r;
                out_dz <= 1'b0;
                out_to <= 1'b0;
            end else if (wdExpired) begin
                out_q  <= {INPUT_SIZE{1'b0}};
                out_r  <= {INPUT_SIZE{1'b0}};
                out_dz <= 1'b0;
                out_to <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_divider_sequencer.sv
// Directed bench for divider_sequencer with a behavioural iterative divider
// (counter loaded on div_load, decremented while enabled, ready at zero).
module tb_divider_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [9:0] in_n;
    logic [9:0] in_d;
    logic       out_valid;
    logic       out_ready;
    logic [9:0] out_q;
    logic [9:0] out_r;
    logic       out_dz;
    logic       out_to;
    logic       busy;
    logic       div_load;
    logic       div_enable;
    logic [9:0] div_init_counter;
    logic [9:0] div_n;
    logic [9:0] div_d;
    logic [9:0] div_q;
    logic [9:0] div_r;
    logic       div_ready;

    logic [9:0] modelCnt = 10'd0;
    logic [9:0] modelQ   = 10'd0;
    logic [9:0] modelR   = 10'd0;
    logic       forceLow;

    int compared   = 0;
    int mismatched = 0;
    int lat;
    int loads;
    int stray;

    always #5 clk = ~clk;

    divider_sequencer dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_n(in_n), .in_d(in_d),
        .out_valid(out_valid), .out_ready(out_ready), .out_q(out_q), .out_r(out_r),
        .out_dz(out_dz), .out_to(out_to), .busy(busy),
        .div_load(div_load), .div_enable(div_enable), .div_init_counter(div_init_counter),
        .div_n(div_n), .div_d(div_d), .div_q(div_q), .div_r(div_r), .div_ready(div_ready)
    );

    // Behavioural divider stand-in
    always @(posedge clk) begin
        if (div_load) begin
            modelCnt <= div_init_counter;
            modelQ   <= (div_d != 10'd0) ? div_n / div_d : 10'd0;
            modelR   <= (div_d != 10'd0) ? div_n % div_d : 10'd0;
        end else if (div_enable && modelCnt != 10'd0) begin
            modelCnt <= modelCnt - 10'd1;
        end
    end
    assign div_q     = modelQ;
    assign div_r     = modelR;
    assign div_ready = (modelCnt == 10'd0) && !forceLow;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Launch one request from IDLE and count cycles until out_valid (acceptance = cycle 0)
    task automatic runOp(input logic [9:0] n, input logic [9:0] d, output int latOut, output int loadsOut);
        @(negedge clk);
        in_n = n; in_d = d; in_valid = 1'b1;
        check("accept_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        latOut = 0; loadsOut = 0;
        do begin
            @(negedge clk);
            latOut++;
            if (div_load) loadsOut++;
        end while (!out_valid && latOut < 40);
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; in_n = 10'd0; in_d = 10'd0;
        out_ready = 1'b1; forceLow = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_div_load",  32'(div_load),  32'd0);
        check("rst_div_en",    32'(div_enable), 32'd0);
        check("rst_out_q",     32'(out_q),     32'd0);
        check("rst_div_n",     32'(div_n),     32'd0);
        check("init_counter",  32'(div_init_counter), 32'd10);
        rst = 1'b1;

        // Nominal 100/7
        runOp(10'd100, 10'd7, lat, loads);
        check("t1_latency", 32'(lat), 32'd13);
        check("t1_loads",   32'(loads), 32'd1);
        check("t1_q",  32'(out_q), 32'd14);
        check("t1_r",  32'(out_r), 32'd2);
        check("t1_dz", 32'(out_dz), 32'd0);
        check("t1_to", 32'(out_to), 32'd0);
        @(negedge clk);
        check("t1_valid_drop", 32'(out_valid), 32'd0);
        check("t1_in_ready",   32'(in_ready),  32'd1);

        // Divide by zero
        runOp(10'd55, 10'd0, lat, loads);
        check("t2_latency", 32'(lat), 32'd1);
        check("t2_loads",   32'(loads), 32'd0);
        check("t2_q",  32'(out_q), 32'h3FF);
        check("t2_r",  32'(out_r), 32'd55);
        check("t2_dz", 32'(out_dz), 32'd1);
        check("t2_to", 32'(out_to), 32'd0);
        @(negedge clk);
        check("t2_valid_drop", 32'(out_valid), 32'd0);

        // Backpressure with ignored in_valid pulses
        out_ready = 1'b0;
        runOp(10'd1023, 10'd1, lat, loads);
        check("t3_latency", 32'(lat), 32'd13);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("t3_hold_valid", 32'(out_valid), 32'd1);
            check("t3_hold_q",     32'(out_q),     32'd1023);
            check("t3_hold_r",     32'(out_r),     32'd0);
            check("t3_in_ready",   32'(in_ready),  32'd0);
            in_valid = (i % 2 == 0);
            in_n = 10'd5;
            in_d = (i % 3 == 0) ? 10'd0 : 10'd5;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("t3_valid_drop", 32'(out_valid), 32'd0);
        check("t3_div_n_kept", 32'(div_n),     32'd1023);
        check("t3_div_d_kept", 32'(div_d),     32'd1);

        // Back-to-back with in_valid held high
        @(negedge clk);
        in_n = 10'd9; in_d = 10'd4; in_valid = 1'b1;
        @(posedge clk);
        #1 in_n = 10'd1000; in_d = 10'd33;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!out_valid && lat < 40);
        check("t4a_latency", 32'(lat), 32'd13);
        check("t4a_q", 32'(out_q), 32'd2);
        check("t4a_r", 32'(out_r), 32'd1);
        @(negedge clk);
        check("t4_idle_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        check("t4b_load_now", 32'(div_load), 32'd1);
        check("t4b_div_n",    32'(div_n),    32'd1000);
        in_valid = 1'b0;
        lat = 1;
        do begin @(negedge clk); lat++; end while (!out_valid && lat < 40);
        check("t4b_latency", 32'(lat), 32'd13);
        check("t4b_q", 32'(out_q), 32'd30);
        check("t4b_r", 32'(out_r), 32'd10);
        @(negedge clk);
        check("t4b_valid_drop", 32'(out_valid), 32'd0);

        // Watchdog timeout, then a normal op
        forceLow = 1'b1;
        runOp(10'd200, 10'd3, lat, loads);
        check("t5_latency", 32'(lat), 32'd17);
        check("t5_to", 32'(out_to), 32'd1);
        check("t5_q",  32'(out_q),  32'd0);
        check("t5_r",  32'(out_r),  32'd0);
        check("t5_dz", 32'(out_dz), 32'd0);
        @(negedge clk);
        forceLow = 1'b0;
        runOp(10'd100, 10'd7, lat, loads);
        check("t5n_latency", 32'(lat), 32'd13);
        check("t5n_q",  32'(out_q),  32'd14);
        check("t5n_r",  32'(out_r),  32'd2);
        check("t5n_to", 32'(out_to), 32'd0);
        @(negedge clk);

        // Asynchronous reset in the middle of RUN
        @(negedge clk);
        in_n = 10'd100; in_d = 10'd7; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (5) @(negedge clk);
        check("t6_busy_before", 32'(busy), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("t6_in_ready",  32'(in_ready),  32'd1);
        check("t6_busy",      32'(busy),      32'd0);
        check("t6_out_valid", 32'(out_valid), 32'd0);
        check("t6_div_en",    32'(div_enable), 32'd0);
        check("t6_div_load",  32'(div_load),  32'd0);
        check("t6_div_n",     32'(div_n),     32'd0);
        check("t6_out_q",     32'(out_q),     32'd0);
        check("t6_out_to",    32'(out_to),    32'd0);
        @(negedge clk);
        rst = 1'b1;
        stray = 0;
        repeat (25) begin
            @(negedge clk);
            if (out_valid) stray++;
        end
        check("t6_no_result", 32'(stray), 32'd0);
        check("t6_idle_ready", 32'(in_ready), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
